// File: rtl/lms_filter.sv
// lms_filter: adaptive LMS FIR filter with saturating weight update.
module lms_filter #(
    parameter int DATA_WIDTH   = 32,
    parameter int FILTER_ORDER = 5,
    parameter int MU_BITS      = 11
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [DATA_WIDTH-1:0] x_in,
    input  logic [DATA_WIDTH-1:0] d_in,
    input  logic [DATA_WIDTH-1:0] y_in,
    output logic [DATA_WIDTH-1:0] y_out,
    output logic [DATA_WIDTH-1:0] err_out
);
    localparam int PW = 2 * DATA_WIDTH;
    localparam int SW = PW + $clog2(FILTER_ORDER);
    logic signed [DATA_WIDTH-1:0] x_q [FILTER_ORDER];
    logic signed [DATA_WIDTH-1:0] x_d [FILTER_ORDER];
    logic signed [DATA_WIDTH-1:0] w_q [FILTER_ORDER];
    logic signed [DATA_WIDTH-1:0] w_d [FILTER_ORDER];
    logic signed [DATA_WIDTH-1:0] d_q, d_d, y_q, y_d, e_q, e_d;
    logic signed [PW-1:0]         xw [FILTER_ORDER];
    logic signed [PW-1:0]         upd_p [FILTER_ORDER];
    logic signed [DATA_WIDTH-1:0] upd [FILTER_ORDER];
    logic signed [DATA_WIDTH:0]   w_sum [FILTER_ORDER];
    logic signed [SW-1:0]         psum [FILTER_ORDER];
    logic signed [DATA_WIDTH:0]   e_w;
    logic signed [DATA_WIDTH-1:0] y_c, e_c;
    logic                         unused_y;
    // Clamp when the bits above the result's sign bit disagree with it.
    function automatic logic signed [DATA_WIDTH-1:0] sat(input logic signed [SW-1:0] v);
        logic [SW-DATA_WIDTH:0] hi;
        hi = v[SW-1:DATA_WIDTH-1];
        return (&hi || ~|hi) ? v[DATA_WIDTH-1:0] : {v[SW-1], {(DATA_WIDTH-1){~v[SW-1]}}};
    endfunction
    assign unused_y = ^y_in;
    assign y_out    = y_q;
    assign err_out  = e_q;
    always_comb begin
        for (int i = 0; i < FILTER_ORDER; i++) xw[i] = PW'(w_q[i]) * PW'(x_q[i]);
        psum[0] = SW'(xw[0]);
        for (int i = 1; i < FILTER_ORDER; i++) psum[i] = psum[i-1] + SW'(xw[i]);
        y_c = sat(psum[FILTER_ORDER-1] >>> MU_BITS);
        e_w = (DATA_WIDTH+1)'(d_q) - (DATA_WIDTH+1)'(y_c);
        e_c = sat(SW'(e_w));
        for (int i = 0; i < FILTER_ORDER; i++) begin
            upd_p[i] = PW'(e_c) * PW'(x_q[i]);
            upd[i]   = sat(SW'(upd_p[i]));
            w_sum[i] = (DATA_WIDTH+1)'(w_q[i]) + (DATA_WIDTH+1)'(upd[i]);
            w_d[i]   = sat(SW'(w_sum[i]));
        end
        x_d[0] = x_in;
        for (int i = 1; i < FILTER_ORDER; i++) x_d[i] = x_q[i-1];
        d_d = d_in;
        y_d = y_c;
        e_d = e_c;
    end
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < FILTER_ORDER; i++) begin
                x_q[i] <= '0;
                w_q[i] <= '0;
            end
            d_q <= '0;
            y_q <= '0;
            e_q <= '0;
        end else begin
            for (int i = 0; i < FILTER_ORDER; i++) begin
                x_q[i] <= x_d[i];
                w_q[i] <= w_d[i];
            end
            d_q <= d_d;
            y_q <= y_d;
            e_q <= e_d;
        end
    end
endmodule

// File: tb/tb_lms_filter.sv
// tb_lms_filter: randomized scoreboard bench for lms_filter against a wide-integer reference model.
module tb_lms_filter;
    localparam int W  = 32;
    localparam int N  = 5;
    localparam int MU = 11;
    localparam logic signed [127:0] HI = 128'sd2147483647;
    localparam logic signed [127:0] LO = -128'sd2147483648;
    typedef struct packed {
        logic [W-1:0]        y;
        logic [W-1:0]        e;
        logic [N-1:0][W-1:0] w;
    } exp_t;
    logic clk = 0;
    logic reset = 1;
    logic [W-1:0] x_in = '0, d_in = '0, y_in = '0;
    logic [W-1:0] y_out, err_out;
    int checks = 0;
    int errors = 0;
    exp_t q[$];
    logic signed [W-1:0] m_x [N];
    logic signed [W-1:0] m_w [N];
    logic signed [W-1:0] m_d;
    lms_filter #(.DATA_WIDTH(W), .FILTER_ORDER(N), .MU_BITS(MU)) dut (
        .clk(clk), .reset(reset), .x_in(x_in), .d_in(d_in), .y_in(y_in),
        .y_out(y_out), .err_out(err_out)
    );
    always #5 clk = ~clk;
    function automatic logic signed [W-1:0] clamp(input logic signed [127:0] v);
        if (v > HI) return HI[W-1:0];
        if (v < LO) return LO[W-1:0];
        return v[W-1:0];
    endfunction
    function automatic logic [N-1:0][W-1:0] dut_w();
        logic [N-1:0][W-1:0] r;
        for (int i = 0; i < N; i++) r[i] = dut.w_q[i];
        return r;
    endfunction
    task automatic model_step(input bit r, input logic signed [W-1:0] x, input logic signed [W-1:0] d);
        exp_t t;
        logic signed [127:0] acc, tmp;
        logic signed [W-1:0] yc, ec;
        t = '0;
        if (r) begin
            for (int i = 0; i < N; i++) begin
                m_x[i] = 0;
                m_w[i] = 0;
            end
            m_d = 0;
        end else begin
            acc = 0;
            for (int i = 0; i < N; i++) begin
                tmp = m_w[i];
                acc = acc + tmp * m_x[i];
            end
            yc = clamp(acc >>> MU);
            tmp = m_d;
            ec = clamp(tmp - yc);
            for (int i = 0; i < N; i++) begin
                tmp = ec;
                tmp = clamp(tmp * m_x[i]);
                m_w[i] = clamp(tmp + m_w[i]);
            end
            for (int i = N - 1; i > 0; i--) m_x[i] = m_x[i-1];
            m_x[0] = x;
            m_d = d;
            t.y = yc;
            t.e = ec;
            for (int i = 0; i < N; i++) t.w[i] = m_w[i];
        end
        q.push_back(t);
    endtask
    task automatic step(input bit r, input logic [W-1:0] x, input logic [W-1:0] d);
        @(negedge clk);
        reset = r;
        x_in = x;
        d_in = d;
        y_in = $urandom;
        model_step(r, x, d);
    endtask
    task automatic spot(input string name, input logic [W-1:0] act, input logic [W-1:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s got %0h want %0h", name, act, req);
        end
    endtask
    task automatic after_edge();
        @(posedge clk);
        #2;
    endtask
    task automatic impulse();
        step(1, $urandom, $urandom);
        step(0, 1, 2048);
        step(0, 0, 0);
    endtask
    always begin
        exp_t t;
        @(posedge clk);
        #1;
        if (q.size() != 0) begin
            t = q.pop_front();
            checks++;
            if (y_out !== t.y || err_out !== t.e || dut_w() !== t.w) begin
                errors++;
                $display("FAIL scoreboard t=%0t y=%0h/%0h e=%0h/%0h w=%0h/%0h",
                         $time, y_out, t.y, err_out, t.e, dut_w(), t.w);
            end
        end
    end
    initial begin
        logic [W-1:0] x, d;
        step(1, $urandom, $urandom);
        step(1, $urandom, $urandom);
        after_edge();
        spot("reset_y", y_out, 0);
        spot("reset_w0", dut.w_q[0], 0);
        for (int i = 0; i < 6; i++) step(0, 1, 0);
        after_edge();
        spot("pass_err", err_out, 0);
        impulse();
        after_edge();
        spot("impulse_y", y_out, 0);
        spot("impulse_err", err_out, 2048);
        spot("impulse_w0", dut.w_q[0], 2048);
        for (int i = 0; i < 5; i++) step(0, 0, 0);
        after_edge();
        spot("impulse_err0", err_out, 0);
        spot("impulse_hold", dut.w_q[0], 2048);
        step(0, 5, 5);
        step(0, 0, 0);
        after_edge();
        spot("gain_y", y_out, 5);
        spot("gain_err", err_out, 0);
        impulse();
        step(0, 0, 0);
        step(1, $urandom, $urandom);
        step(0, 5, 0);
        step(0, 0, 0);
        after_edge();
        spot("midreset_y", y_out, 0);
        step(1, 0, 0);
        for (int i = 0; i < 12; i++) step(0, 32'h7FFFFFFF, 32'h7FFFFFFF);
        after_edge();
        spot("sat_y", y_out, 32'h7FFFFFFF);
        spot("sat_w0", dut.w_q[0], 32'h7FFFFFFF);
        for (int i = 0; i < 8; i++) step(0, 32'h80000000, 32'h7FFFFFFF);
        for (int i = 0; i < 400; i++) begin
            case ($urandom_range(0, 3))
                0: x = $urandom;
                1: x = 0;
                default: x = W'($signed($urandom_range(0, 400)) - 200);
            endcase
            d = ($urandom_range(0, 3) == 0) ? $urandom : W'($signed($urandom_range(0, 20000)) - 10000);
            step($urandom_range(0, 39) == 0, x, d);
        end
        @(negedge clk);
        reset = 1;
        repeat (3) @(negedge clk);
        checks++;
        if (q.size() != 0) begin
            errors++;
            $display("FAIL drain left %0d want 0", q.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/lms_filter.md
LMS_FILTER -- requirements
Module: lms_filter

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 32, signed sample/weight/output width.
REQ-002 SHALL have parameter FILTER_ORDER, default 5, number of taps (legal range 2..64).
REQ-003 SHALL have parameter MU_BITS, default 11.
- Step size mu = 2^-MU_BITS.
- Weights carry MU_BITS fractional bits.
REQ-004 clk  input  1  single clock, all state updates on rising edge.
REQ-005 reset  input  1  synchronous, active-high reset.
REQ-006 x_in  input  DATA_WIDTH  signed filter input sample, sampled every cycle.
REQ-007 d_in  input  DATA_WIDTH  signed desired sample, sampled every cycle.
REQ-008 y_in  input  DATA_WIDTH  signed reference output; sampled but SHALL have no effect on any output or state.
REQ-009 y_out  output  DATA_WIDTH  signed registered filter output.
REQ-010 err_out  output  DATA_WIDTH  signed registered error (desired minus output).

Function
REQ-011 SHALL hold a tap line x_reg[0..FILTER_ORDER-1].
- Each cycle: x_reg[0]<=x_in and x_reg[i]<=x_reg[i-1].
- No input enable; a new sample is taken every cycle.
REQ-012 SHALL register d_reg<=d_in in the same edge, so d_reg stays aligned with x_reg[0].
REQ-013 SHALL hold weights w_reg[0..FILTER_ORDER-1], signed DATA_WIDTH, raw value = real weight * 2^MU_BITS.
REQ-014 Products SHALL be full 2*DATA_WIDTH-bit signed: xw[i]=w_reg[i]*x_reg[i].
REQ-015 Products SHALL be summed as a combinational chain of FILTER_ORDER-1 partial sums.
- The sum SHALL use width 2*DATA_WIDTH+ceil(log2(FILTER_ORDER)), so it cannot overflow.
REQ-016 y_c SHALL equal the sum arithmetically shifted right by MU_BITS, then saturated to DATA_WIDTH signed range.
REQ-017 e_c SHALL equal d_reg - y_c, computed in DATA_WIDTH+1 bits, then saturated to DATA_WIDTH.
REQ-018 Each rising edge with reset low SHALL perform y_out<=y_c and err_out<=e_c.
REQ-019 Each rising edge with reset low SHALL update every weight, in the same edge as the tap shift and using pre-edge values:
- w_reg[i] <= sat(w_reg[i] + sat(e_c*x_reg[i])), saturation to DATA_WIDTH signed.
REQ-020 Latency: x_in/d_in applied before edge k affect y_out/err_out after edge k+1 (two edges).
REQ-021 Weight change caused by sample at edge k SHALL first affect y_c after edge k+1.
REQ-022 Saturation SHALL clamp to +2^(DATA_WIDTH-1)-1 / -2^(DATA_WIDTH-1); no wrap-around anywhere.
REQ-023 x_in=0 on all taps SHALL leave weights unchanged, independent of error.

Reset
REQ-024 While reset=1 at a rising edge, x_reg, d_reg, w_reg, y_out and err_out SHALL all become 0.
REQ-025 Reset SHALL dominate any simultaneous data update.
REQ-026 Reset asserted mid-operation SHALL discard all learned weights.
- The first post-reset output SHALL be computed with zero weights.
REQ-027 Outputs are undefined before the first reset edge; the bench SHALL apply reset for at least one edge.

Verification (DATA_WIDTH=32, FILTER_ORDER=5, MU_BITS=11)
REQ-028 Reset test: hold reset 2 cycles with arbitrary x_in/d_in.
- Required: y_out=0, err_out=0, all w_reg=0.
REQ-029 Zero-weight pass-through: after reset, x_in=1 and d_in=0 every cycle.
- Required: y_out=0 and err_out=0 on every cycle; weights remain 0.
REQ-030 Impulse learning: one cycle x_in=1, d_in=2048, then x_in=0, d_in=0.
- After second edge: err_out=2048, y_out=0, w_reg[0]=2048.
- Then err_out=0 and w_reg[0] stays 2048.
REQ-031 Learned-gain check: following REQ-030, apply x_in=5, d_in=5 for one cycle.
- Two edges later: y_out=5, err_out=0.
REQ-032 Saturation: after reset, x_in=32'h7FFFFFFF and d_in=32'h7FFFFFFF repeatedly.
- Weights, y_out and err_out SHALL clamp at 32'h7FFFFFFF / 32'h80000000 and never change sign by wrap.
REQ-033 Mid-run reset: learn as in REQ-030, assert reset one cycle, then apply x_in=5, d_in=0.
- Required: y_out=0, confirming the weights were cleared.
